// File: rtl/debounce_pkg.sv
// debounce_pkg: per-button state encodings and default timing constants for debounce_sched.
package debounce_pkg;
  typedef enum logic [2:0] {
    REL    = 3'd0,
    REQ_DN = 3'd1,
    TMR_DN = 3'd2,
    PRS    = 3'd3,
    REQ_UP = 3'd4,
    TMR_UP = 3'd5
  } btn_st_e;
  localparam int DEB_CNT_DEF = 1000000;
  localparam int CNT_W_DEF   = 32;
  function automatic logic deb_lvl(input btn_st_e s);
    return !(s == PRS || s == REQ_UP || s == TMR_UP);
  endfunction
endpackage

// File: rtl/debounce_rr_arb.sv
// debounce_rr_arb: combinational round-robin pick, searching upward from last_grant+1 with wrap.
module debounce_rr_arb
  import debounce_pkg::*;
#(
  parameter int N_BTN = 4,
  localparam int IW = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
  input  logic [N_BTN-1:0] req,
  input  logic [IW-1:0]    last_grant,
  output logic             gnt_valid,
  output logic [IW-1:0]    gnt_idx
);
  logic [IW-1:0] j;
  // Walk from the farthest candidate down so the nearest one after last_grant wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    j         = '0;
    for (int k = N_BTN; k >= 1; k--) begin
      j = IW'((int'(last_grant) + k) % N_BTN);
      if (req[j]) begin
        gnt_valid = 1'b1;
        gnt_idx   = j;
      end
    end
  end
endmodule

// File: rtl/debounce_sched.sv
// debounce_sched: N active-low buttons debounced through one shared, round-robin arbitrated timer.
// Define DEBOUNCE_SCHED_RELEASE_PULSE_EN to add release_pulse_o.
module debounce_sched
  import debounce_pkg::*;
#(
  parameter int N_BTN   = 4,
  parameter int DEB_CNT = DEB_CNT_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  localparam int IW = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N_BTN-1:0] but_in,
  output logic [N_BTN-1:0] but_deb_o,
  output logic [N_BTN-1:0] press_pulse_o,
  output logic             tmr_busy_o,
  output logic [IW-1:0]    tmr_owner_o
`ifdef DEBOUNCE_SCHED_RELEASE_PULSE_EN
  ,
  output logic [N_BTN-1:0] release_pulse_o
`endif
);
  btn_st_e          st    [N_BTN];
  btn_st_e          st_nx [N_BTN];
  logic [N_BTN-1:0] req, lvl;
  logic [CNT_W-1:0] cnt;
  logic [IW-1:0]    last_grant, gnt_idx;
  logic             gnt_valid, grant, done;
  assign done  = tmr_busy_o && cnt == CNT_W'(DEB_CNT - 1);
  assign grant = !tmr_busy_o && gnt_valid;
  debounce_rr_arb #(.N_BTN(N_BTN)) u_arb (
    .req        (req),
    .last_grant (last_grant),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx)
  );
  // A button in TMR_* that does not own a running timer is treated as corrupt and released.
  always_comb begin
    req = '0;
    lvl = '1;
    for (int i = 0; i < N_BTN; i++) begin
      req[i] = st[i] == REQ_DN || st[i] == REQ_UP;
      lvl[i] = deb_lvl(st[i]);
      case (st[i])
        REL:     st_nx[i] = but_in[i] ? REL : REQ_DN;
        REQ_DN:  st_nx[i] = (grant && gnt_idx == IW'(i)) ? TMR_DN : but_in[i] ? REL : REQ_DN;
        TMR_DN:  st_nx[i] = !(tmr_busy_o && tmr_owner_o == IW'(i)) ? REL :
                            !done ? TMR_DN : but_in[i] ? REL : PRS;
        PRS:     st_nx[i] = but_in[i] ? REQ_UP : PRS;
        REQ_UP:  st_nx[i] = (grant && gnt_idx == IW'(i)) ? TMR_UP : but_in[i] ? REQ_UP : PRS;
        TMR_UP:  st_nx[i] = !(tmr_busy_o && tmr_owner_o == IW'(i)) ? REL :
                            !done ? TMR_UP : but_in[i] ? REL : PRS;
        default: st_nx[i] = REL;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N_BTN; i++) st[i] <= REL;
    end else begin
      for (int i = 0; i < N_BTN; i++) st[i] <= st_nx[i];
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tmr_busy_o  <= 1'b0;
      cnt         <= '0;
      tmr_owner_o <= '0;
      last_grant  <= IW'(N_BTN - 1);
    end else if (grant) begin
      tmr_busy_o  <= 1'b1;
      cnt         <= '0;
      tmr_owner_o <= gnt_idx;
      last_grant  <= gnt_idx;
    end else if (done) begin
      tmr_busy_o  <= 1'b0;
      cnt         <= '0;
    end else if (tmr_busy_o) begin
      cnt <= cnt + 1'b1;
    end
  end
  // Outputs follow the state register by one cycle; pulses mark edges of the debounced level.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      but_deb_o       <= '1;
      press_pulse_o   <= '0;
`ifdef DEBOUNCE_SCHED_RELEASE_PULSE_EN
      release_pulse_o <= '0;
`endif
    end else begin
      but_deb_o       <= lvl;
      press_pulse_o   <= but_deb_o & ~lvl;
`ifdef DEBOUNCE_SCHED_RELEASE_PULSE_EN
      release_pulse_o <= ~but_deb_o & lvl;
`endif
    end
  end
endmodule

// File: doc/debounce_sched.md
Name: debounce_sched

Overview:
- Debounces N_BTN active-low push buttons using one shared debounce timer instead of one wide counter per button.
- Each button has a small per-button state machine. The buttons compete for the timer through a round-robin arbiter.
- Sits between the raw (already synchronised) button pins and the user logic.
- Provides a debounced level and a one-cycle press pulse for each button.

Parameters:
- N_BTN, 4, number of buttons (range 1..16).
- DEB_CNT, 1000000, debounce window in clk cycles (must be >= 2).
- CNT_W, 32, timer width; must hold DEB_CNT-1.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rstn  input  1  asynchronous active-low reset.
- but_in  input  N_BTN  raw button levels; 0 = pressed.
- but_deb_o  output  N_BTN  debounced levels; 0 = pressed. Reset value all 1.
- press_pulse_o  output  N_BTN  one-cycle high when a press is confirmed. Reset value 0.
- tmr_busy_o  output  1  shared timer running. Reset value 0.
- tmr_owner_o  output  $clog2(N_BTN) (min 1)  index of the current timer owner. Reset value 0.

Behaviour:
Interface:
- One clock, clk.
- Reset rstn is asynchronous, active-low.
- All state is registered and all outputs are driven from registers.

Per-button FSM (states and debounced output level):
- REL (deb 1): if but_in[i]==0, go to REQ_DN.
- REQ_DN (deb 1): requests the timer.
  - If granted, go to TMR_DN.
  - Else if but_in[i]==1, cancel and go to REL.
- TMR_DN (deb 1): waits for tmr_done while owner == i.
  - If but_in[i]==0 at done, go to PRS and raise press_pulse_o[i] in the next cycle.
  - Otherwise go to REL.
- PRS (deb 0): if but_in[i]==1, go to REQ_UP.
- REQ_UP (deb 0): requests the timer.
  - If granted, go to TMR_UP.
  - Else if but_in[i]==0, go to PRS.
- TMR_UP (deb 0): at tmr_done:
  - If but_in[i]==1, go to REL.
  - Otherwise go to PRS.
- Illegal encodings go to REL.

Shared timer and arbiter:
- Request vector: req[i] = state is REQ_DN or REQ_UP.
- Grant condition: timer idle and req != 0.
- Grant selection: round-robin, searching upward from last_grant+1 with wrap.
- At the grant edge: timer goes busy, cnt = 0, owner = the granted index, last_grant = owner.
- While busy, cnt increments each cycle.
- tmr_done = busy && cnt == DEB_CNT-1. The owner therefore spends exactly DEB_CNT cycles in TMR_*.
- At the done edge the timer returns to idle. The next grant is issued no earlier than the following cycle.

Timing:
- Latency from the but_in fall to but_deb_o fall for an uncontended button: 1 cycle to REQ_DN, +1 cycle to grant, +DEB_CNT cycles of timing, +1 cycle to PRS. That is DEB_CNT+3 cycles.
- press_pulse_o[i] is high in the same cycle but_deb_o[i] first reads 0.

Boundary rules:
- Grant and a cancelling but_in edge in the same cycle: grant wins, and the button enters TMR_*. The sample taken at done decides the outcome.
- Bounces during TMR_* are ignored; only the level at tmr_done matters.
- All N_BTN requesting at once: serviced in round-robin order. Worst-case wait is (N_BTN-1)*(DEB_CNT+1) cycles.
- Non-owner buttons in TMR_* cannot occur; if such a state is detected, that button goes to REL.
- rstn low mid-operation: all FSMs go to REL, timer idle, cnt=0, owner=0, last_grant=N_BTN-1 (so button 0 wins first), all outputs return to their reset values.

Optional Feature:
- Macro: DEBOUNCE_SCHED_RELEASE_PULSE_EN.
- Defined:
  - Adds output port release_pulse_o [N_BTN], reset value 0.
  - release_pulse_o[i] pulses for one cycle when TMR_UP goes to REL, coincident with but_deb_o[i] rising.
- Undefined:
  - The port is absent and no release logic is built.
  - All other behaviour is identical.

Decomposition:
- Shared package debounce_pkg:
  - 3-bit per-button state encodings: REL=0, REQ_DN=1, TMR_DN=2, PRS=3, REQ_UP=4, TMR_UP=5.
  - Default DEB_CNT and CNT_W constants.
- One sub-module, debounce_rr_arb:
  - Combinational round-robin pick from req and last_grant.
  - Outputs gnt_valid and gnt_idx.
- Per-button FSMs are generated inline; the timer lives in the top.

Test Plan:
Use N_BTN=4, DEB_CNT=8 for all scenarios.
- Clean press: but_in[0] goes 1 to 0 and is held.
  - but_deb_o[0] falls 11 cycles later.
  - press_pulse_o[0] is high for exactly that one cycle.
  - tmr_busy_o is high for 8 cycles.
- Glitch: but_in[1] is low for 3 cycles, then back to 1 during TMR_DN.
  - but_deb_o[1] stays 1 and no pulse is issued.
  - Timer still runs its full 8 cycles, then goes idle.
- Contention: but_in[3:0] all fall in the same cycle.
  - Grants go in order 0,1,2,3, spaced 9 cycles apart.
  - press_pulse_o fires in that order, and each button's deb falls.
- Cancel before grant: btn 0 owns the timer while btn 2 drops low for 2 cycles and then rises.
  - btn 2 goes REQ_DN then REL.
  - btn 2 is never granted; tmr_owner_o never equals 2.
- Release with macro defined: btn 0 is in PRS and but_in[0] rises.
  - but_deb_o[0] rises 11 cycles later, with release_pulse_o[0] high for 1 cycle.
- Reset mid-timer: rstn asserted for 1 cycle at cnt=4.
  - Immediately: all deb outputs 1, pulses 0, tmr_busy_o 0.
  - After release of reset, a btn 0 request is granted first.
